miner_job_ctrl: RTL and testbench

- Upstream job controller for the Miner core.
- Holds the header blob in a word buffer written by the host, and serves it word-by-word on the Miner's Next handshake.
- Generates and advances the nonce and pulses Update per attempt, then evaluates Rdy/Vld.
- Stops on a found nonce, on the iteration limit, or on a host abort; reports the winning nonce and hash.

---
 rtl/miner_job_ctrl.sv | 204 ++++++++++++++++++++
 tb/tb_miner_job_ctrl.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/miner_job_ctrl.sv
`timescale 1ns/1ps
// Upstream job controller for the Miner core: serves the host-written header
// word by word, steps the nonce per attempt and records the winning nonce/hash.
module miner_job_ctrl #(
    parameter int NONCE_BYTE_LEN = 24,
    parameter int BUF_WORDS      = 256,
    parameter int NONCE_STEP     = 1,
    localparam int NW            = NONCE_BYTE_LEN * 8,
    localparam int AW            = $clog2(BUF_WORDS)
) (
    input  logic           Clk,
    input  logic           Rst_n,
    input  logic           HostWr_I,
    input  logic [AW-1:0]  HostAddr_I,
    input  logic [31:0]    HostData_I,
    input  logic           Start_I,
    input  logic           Abort_I,
    input  logic [10:0]    ByteNum_I,
    input  logic [NW-1:0]  NonceInit_I,
    input  logic [31:0]    MaxIter_I,
    input  logic           MinerNext_I,
    input  logic           MinerRdy_I,
    input  logic           MinerVld_I,
    input  logic [255:0]   MinerHash_I,
    output logic           MinerUpdate_O,
    output logic           MinerClear_O,
    output logic [31:0]    Msg_O,
    output logic [10:0]    ByteNum_O,
    output logic [NW-1:0]  Nonce_O,
    output logic           Busy_O,
    output logic           Done_O,
    output logic           Found_O,
    output logic [NW-1:0]  FoundNonce_O,
    output logic [255:0]   FoundHash_O,
    output logic [31:0]    IterCnt_O
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LAUNCH = 3'd1,
        S_WAIT   = 3'd2,
        S_EVAL   = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    state_t          state_q, state_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic            first_q, first_d;
    logic [10:0]     byte_num_q, byte_num_d;
    logic [NW-1:0]   nonce_q, nonce_d;
    logic [31:0]     max_iter_q, max_iter_d;
    logic [31:0]     iter_q, iter_d;
    logic [31:0]     iter_inc;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            found_q, found_d;
    logic            clear_q, clear_d;
    logic [NW-1:0]   found_nonce_q, found_nonce_d;
    logic [255:0]    found_hash_q, found_hash_d;
    logic [31:0]     hdr_mem_q [BUF_WORDS];

    // Header buffer: host writes are accepted in every state, no reset.
    always_ff @(posedge Clk) begin
        if (HostWr_I) begin
            hdr_mem_q[HostAddr_I] <= HostData_I;
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q       <= S_IDLE;
            rd_ptr_q      <= '0;
            first_q       <= 1'b0;
            byte_num_q    <= '0;
            nonce_q       <= '0;
            max_iter_q    <= '0;
            iter_q        <= '0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            found_q       <= 1'b0;
            clear_q       <= 1'b0;
            found_nonce_q <= '0;
            found_hash_q  <= '0;
        end else begin
            state_q       <= state_d;
            rd_ptr_q      <= rd_ptr_d;
            first_q       <= first_d;
            byte_num_q    <= byte_num_d;
            nonce_q       <= nonce_d;
            max_iter_q    <= max_iter_d;
            iter_q        <= iter_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            found_q       <= found_d;
            clear_q       <= clear_d;
            found_nonce_q <= found_nonce_d;
            found_hash_q  <= found_hash_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        first_d       = 1'b0;
        byte_num_d    = byte_num_q;
        nonce_d       = nonce_q;
        max_iter_d    = max_iter_q;
        iter_d        = iter_q;
        busy_d        = busy_q;
        done_d        = done_q;
        found_d       = found_q;
        clear_d       = 1'b0;
        found_nonce_d = found_nonce_q;
        found_hash_d  = found_hash_q;
        iter_inc      = (iter_q == '1) ? iter_q : iter_q + 32'd1;

        unique case (state_q)
            S_IDLE: begin
                if (Start_I) begin
                    byte_num_d    = ByteNum_I;
                    nonce_d       = NonceInit_I;
                    max_iter_d    = MaxIter_I;
                    iter_d        = '0;
                    busy_d        = 1'b1;
                    done_d        = 1'b0;
                    found_d       = 1'b0;
                    found_nonce_d = '0;
                    found_hash_d  = '0;
                    state_d       = S_LAUNCH;
                end
            end
            S_LAUNCH: begin
                first_d = 1'b1;
                state_d = S_WAIT;
            end
            // The Miner drops Rdy only after seeing Update, so the first WAIT cycle may still show the previous result.
            S_WAIT: begin
                if (MinerRdy_I && !first_q) begin
                    state_d = S_EVAL;
                end
            end
            S_EVAL: begin
                iter_d = iter_inc;
                if (MinerVld_I) begin
                    found_nonce_d = nonce_q;
                    found_hash_d  = MinerHash_I;
                    found_d       = 1'b1;
                    busy_d        = 1'b0;
                    done_d        = 1'b1;
                    state_d       = S_DONE;
                end else if ((max_iter_q != '0) && (iter_inc == max_iter_q)) begin
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = S_DONE;
                end else begin
                    nonce_d = nonce_q + NW'(NONCE_STEP);
                    state_d = S_LAUNCH;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Abort overrides whatever the active state decided this cycle.
        if (Abort_I && (state_q inside {S_LAUNCH, S_WAIT, S_EVAL})) begin
            state_d       = S_IDLE;
            first_d       = 1'b0;
            clear_d       = 1'b1;
            busy_d        = 1'b0;
            done_d        = 1'b0;
            found_d       = 1'b0;
            iter_d        = iter_q;
            nonce_d       = nonce_q;
            found_nonce_d = found_nonce_q;
            found_hash_d  = found_hash_q;
        end

        if (state_q == S_LAUNCH) begin
            rd_ptr_d = '0;
        end else if (MinerNext_I) begin
            rd_ptr_d = (rd_ptr_q == AW'(BUF_WORDS - 1)) ? '0 : rd_ptr_q + AW'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
    end

    always_comb begin
        MinerUpdate_O = (state_q == S_LAUNCH);
        MinerClear_O  = clear_q;
        Msg_O         = hdr_mem_q[rd_ptr_q];
        ByteNum_O     = byte_num_q;
        Nonce_O       = nonce_q;
        Busy_O        = busy_q;
        Done_O        = done_q;
        Found_O       = found_q;
        FoundNonce_O  = found_nonce_q;
        FoundHash_O   = found_hash_q;
        IterCnt_O     = iter_q;
    end

endmodule

// File: tb/tb_miner_job_ctrl.sv
`timescale 1ns/1ps
// Bench for miner_job_ctrl: a behavioural Miner answers Update/Next, and each
// job's attempted nonces and outcome are predicted from the job rules alone.
module tb_miner_job_ctrl;

    localparam int NW = 192;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           host_wr = 1'b0;
    logic [7:0]     host_addr = '0;
    logic [31:0]    host_data = '0;
    logic           start = 1'b0;
    logic           abort = 1'b0;
    logic [10:0]    byte_num = '0;
    logic [NW-1:0]  nonce_init = '0;
    logic [31:0]    max_iter = '0;
    logic           miner_next = 1'b0;
    logic           miner_rdy = 1'b0;
    logic           miner_vld = 1'b0;
    logic [255:0]   miner_hash = '0;
    logic           update_o, clear_o, busy_o, done_o, found_o;
    logic [31:0]    msg_o, iter_o;
    logic [10:0]    byte_num_o;
    logic [NW-1:0]  nonce_o, found_nonce_o;
    logic [255:0]   found_hash_o;

    int vecs = 0;
    int errs = 0;

    logic [31:0]    exp_buf [256];
    logic [NW-1:0]  exp_q [$];
    int             upd_cnt = 0;
    int             cfg_nw = 0;
    bit             cfg_has_t = 1'b0;
    bit             cfg_lag = 1'b0;
    logic [NW-1:0]  cfg_t = '0;
    logic [255:0]   cfg_hash = '0;

    bit             m_active = 1'b0;
    bit             m_lag = 1'b0;
    int             m_widx = 0;
    int             m_wait = 0;
    logic [NW-1:0]  m_nonce = '0;

    miner_job_ctrl dut (
        .Clk          (clk),
        .Rst_n        (rst_n),
        .HostWr_I     (host_wr),
        .HostAddr_I   (host_addr),
        .HostData_I   (host_data),
        .Start_I      (start),
        .Abort_I      (abort),
        .ByteNum_I    (byte_num),
        .NonceInit_I  (nonce_init),
        .MaxIter_I    (max_iter),
        .MinerNext_I  (miner_next),
        .MinerRdy_I   (miner_rdy),
        .MinerVld_I   (miner_vld),
        .MinerHash_I  (miner_hash),
        .MinerUpdate_O(update_o),
        .MinerClear_O (clear_o),
        .Msg_O        (msg_o),
        .ByteNum_O    (byte_num_o),
        .Nonce_O      (nonce_o),
        .Busy_O       (busy_o),
        .Done_O       (done_o),
        .Found_O      (found_o),
        .FoundNonce_O (found_nonce_o),
        .FoundHash_O  (found_hash_o),
        .IterCnt_O    (iter_o)
    );

    always #5 clk = ~clk;

    initial begin
        #3_000_000;
        $display("FAIL watchdog: observed no end of run, expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [NW-1:0] rand_nonce();
        logic [NW-1:0] r;
        for (int i = 0; i < NW / 32; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    function automatic logic [255:0] rand_hash();
        logic [255:0] r;
        for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    // Behavioural Miner: reacts to Update/Clear, fetches its header words, then reports a result.
    always @(negedge clk) begin
        miner_next = 1'b0;
        if (clear_o) begin
            miner_rdy = 1'b0;
            miner_vld = 1'b0;
            m_active  = 1'b0;
        end else if (update_o) begin
            upd_cnt++;
            chk("upd_expected", 256'(exp_q.size() != 0), 256'(1));
            if (exp_q.size() != 0) chk("upd_nonce", 256'(nonce_o), 256'(exp_q.pop_front()));
            m_active = 1'b1;
            m_lag    = cfg_lag;
            m_widx   = 0;
            m_wait   = $urandom_range(1, 4);
            m_nonce  = nonce_o;
            if (!cfg_lag) begin
                miner_rdy = 1'b0;
                miner_vld = 1'b0;
            end
        end else if (m_active) begin
            if (m_lag) begin
                miner_rdy = 1'b0;
                miner_vld = 1'b0;
                m_lag     = 1'b0;
            end
            if (m_widx < cfg_nw) begin
                chk("msg_word", 256'(msg_o), 256'(exp_buf[m_widx]));
                miner_next = 1'b1;
                m_widx++;
            end else if (m_wait > 0) begin
                m_wait--;
            end else begin
                miner_rdy  = 1'b1;
                miner_vld  = cfg_has_t && (m_nonce == cfg_t);
                miner_hash = miner_vld ? cfg_hash : rand_hash();
                m_active   = 1'b0;
            end
        end
    end

    task automatic run_job(input logic [10:0] bn, input logic [NW-1:0] n0, input logic [31:0] mi,
                           input bit has_t, input logic [NW-1:0] t, input bit lag);
        logic [NW-1:0] n;
        int iters;
        bit found;
        int cyc;
        cfg_nw    = (int'(bn) - 24 + 3) / 4;
        cfg_has_t = has_t;
        cfg_t     = t;
        cfg_lag   = lag;
        cfg_hash  = rand_hash();
        // Reference: walk nonces from n0 until the target or the attempt limit.
        exp_q.delete();
        n = n0;
        iters = 0;
        found = 1'b0;
        while (iters < 1000) begin
            iters++;
            exp_q.push_back(n);
            if (has_t && n == t) begin
                found = 1'b1;
                break;
            end
            if (mi != 0 && iters == int'(mi)) break;
            n = n + NW'(1);
        end
        upd_cnt = 0;
        @(negedge clk);
        start      = 1'b1;
        byte_num   = bn;
        nonce_init = n0;
        max_iter   = mi;
        @(negedge clk);
        start      = 1'b0;
        byte_num   = 11'($urandom);
        nonce_init = rand_nonce();
        max_iter   = $urandom;
        chk("start_busy", 256'(busy_o), 256'(1));
        chk("start_done", 256'(done_o), 256'(0));
        chk("start_found", 256'(found_o), 256'(0));
        chk("start_iter", 256'(iter_o), 256'(0));
        chk("start_bytenum", 256'(byte_num_o), 256'(bn));
        chk("start_nonce", 256'(nonce_o), 256'(n0));
        cyc = 0;
        while (!done_o && cyc < 3000) begin
            @(negedge clk);
            cyc++;
        end
        chk("done_in_time", 256'(done_o), 256'(1));
        chk("end_busy", 256'(busy_o), 256'(0));
        chk("end_found", 256'(found_o), 256'(found));
        chk("end_found_nonce", 256'(found_nonce_o), found ? 256'(n) : 256'(0));
        chk("end_found_hash", found_hash_o, found ? cfg_hash : 256'(0));
        chk("end_iter", 256'(iter_o), 256'(iters));
        chk("end_nonce", 256'(nonce_o), 256'(n));
        chk("end_updates", 256'(upd_cnt), 256'(iters));
        chk("end_queue_empty", 256'(exp_q.size()), 256'(0));
        @(negedge clk);
        @(negedge clk);
        chk("done_sticky", 256'(done_o), 256'(1));
        chk("found_sticky", 256'(found_o), 256'(found));
    endtask

    task automatic run_abort(input logic [NW-1:0] n0);
        int seen;
        int cyc;
        cfg_nw    = 10;
        cfg_has_t = 1'b0;
        cfg_lag   = 1'b0;
        exp_q.delete();
        for (int i = 0; i < 20; i++) exp_q.push_back(n0 + NW'(i));
        @(negedge clk);
        start      = 1'b1;
        byte_num   = 11'd64;
        nonce_init = n0;
        max_iter   = 32'd0;
        @(negedge clk);
        start = 1'b0;
        seen  = 1;
        cyc   = 0;
        while (seen < 2 && cyc < 500) begin
            @(negedge clk);
            cyc++;
            if (update_o) seen++;
        end
        chk("abort_second_update", 256'(seen), 256'(2));
        @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_clear", 256'(clear_o), 256'(1));
        chk("abort_busy", 256'(busy_o), 256'(0));
        chk("abort_done", 256'(done_o), 256'(0));
        chk("abort_found", 256'(found_o), 256'(0));
        chk("abort_iter_hold", 256'(iter_o), 256'(1));
        @(negedge clk);
        chk("abort_clear_one_cycle", 256'(clear_o), 256'(0));
        chk("abort_no_update", 256'(update_o), 256'(0));
        exp_q.delete();
    endtask

    initial begin
        logic [NW-1:0] r;
        logic [31:0]   mi;
        bit            ht;

        repeat (3) @(negedge clk);
        chk("rst_update", 256'(update_o), 256'(0));
        chk("rst_clear", 256'(clear_o), 256'(0));
        chk("rst_busy", 256'(busy_o), 256'(0));
        chk("rst_done", 256'(done_o), 256'(0));
        chk("rst_found", 256'(found_o), 256'(0));
        chk("rst_iter", 256'(iter_o), 256'(0));
        chk("rst_nonce", 256'(nonce_o), 256'(0));
        chk("rst_bytenum", 256'(byte_num_o), 256'(0));
        chk("rst_found_nonce", 256'(found_nonce_o), 256'(0));
        chk("rst_found_hash", found_hash_o, 256'(0));
        rst_n = 1'b1;

        for (int a = 0; a < 256; a++) begin
            @(negedge clk);
            host_wr   = 1'b1;
            host_addr = 8'(a);
            host_data = (a < 10) ? 32'hA0 + 32'(a) : $urandom;
            exp_buf[a] = host_data;
        end
        @(negedge clk);
        host_wr = 1'b0;

        run_job(11'd64, NW'(5), 32'd0, 1'b1, NW'(7), 1'b0);
        run_job(11'd64, rand_nonce(), 32'd4, 1'b0, '0, 1'b0);
        run_job(11'd64, {NW{1'b1}}, 32'd2, 1'b0, '0, 1'b0);

        // Abort while idle must leave the finished job's flags untouched.
        @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("idle_abort_clear", 256'(clear_o), 256'(0));
        chk("idle_abort_done", 256'(done_o), 256'(1));

        r = rand_nonce();
        run_job(11'd24, r, 32'd0, 1'b1, r + NW'(1), 1'b0);
        r = rand_nonce();
        run_job(11'd100, r, 32'd0, 1'b1, r + NW'(2), 1'b1);

        run_abort(rand_nonce());
        r = rand_nonce();
        run_job(11'd64, r, 32'd3, 1'b1, r + NW'(1), 1'b0);

        for (int k = 0; k < 5; k++) begin
            r  = rand_nonce();
            mi = $urandom_range(0, 5);
            ht = (mi == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            run_job(11'($urandom_range(24, 200)), r, mi, ht, r + NW'($urandom_range(0, 4)),
                    1'($urandom_range(0, 1)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
